mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage RV32 pipeline. Consumes the EX/MEM registers produced by execute.
//  - Issues loads/stores to the data-memory bus with a req/ack handshake; wait states are variable.
//  - Aligns store data and byte enables; extracts and extends load data.
//  - Drives the MEM/WB registers and a stall back to the front of the pipeline.

---
 rtl/mem_access_stage_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: FSM states, load funct3 codes,
// MemRW bit positions, access sizes and fault codes.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam int MEMRW_LOAD  = 1;
  localparam int MEMRW_STORE = 0;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  localparam logic [1:0] MEM_FAULT_OK       = 2'b00;
  localparam logic [1:0] MEM_FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] MEM_FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] MEM_FAULT_CONFLICT = 2'b11;

  // Faults detectable before any bus activity. Size 2'b11 is checked as a word.
  function automatic logic [1:0] pre_fault(input logic [1:0] rw, input logic [1:0] ds,
                                           input logic [1:0] lo);
    logic [1:0] f;
    f = MEM_FAULT_OK;
    if (rw == 2'b11)
      f = MEM_FAULT_CONFLICT;
    else if (rw != 2'b00 && ((ds == DSIZE_HALF && lo[0]) || (ds[1] && lo != 2'b00)))
      f = MEM_FAULT_MISALIGN;
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data shift and byte enables, load extract and extend.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  dsize_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_o
);

  logic [4:0]  sh;
  logic [31:0] rsh;

  assign sh = {addr_lo_i, 3'b000};

  // Lane shift for stores, lane extract plus sign/zero extension for loads.
  always_comb begin
    wdata_o = sdata_i << sh;
    rsh     = rdata_i >> sh;
    case (dsize_i)
      DSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      DSIZE_HALF: be_o = 4'b0011 << addr_lo_i;
      default:    be_o = 4'b1111;
    endcase
    case (funct3_i)
      LOAD_LB:  load_o = {{24{rsh[7]}}, rsh[7:0]};
      LOAD_LH:  load_o = {{16{rsh[15]}}, rsh[15:0]};
      LOAD_LW:  load_o = rdata_i;
      LOAD_LBU: load_o = {24'd0, rsh[7:0]};
      LOAD_LHU: load_o = {16'd0, rsh[15:0]};
      default:  load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-bus req/ack sequencing with timeout, and the MEM/WB registers.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        nop,
  input  logic [31:0] ALU_co_pype,
  input  logic [31:0] read_data2_pype2,
  input  logic [31:0] PCp4_pype2,
  input  logic [4:0]  WReg_pype2,
  input  logic [2:0]  writeback_control_pype2,
  input  logic [1:0]  MemRW_pype2,
  input  logic [1:0]  dsize_pype2,
  input  logic [2:0]  funct3_pype2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data_pype3,
  output logic [31:0] ALU_co_pype3,
  output logic [31:0] PCp4_pype3,
  output logic [4:0]  WReg_pype3,
  output logic [2:0]  writeback_control_pype3,
  output logic [1:0]  mem_fault_pype3
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q;
  logic [7:0]  cnt_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] done_load_q;
  logic [1:0]  done_fault_q;

  logic [31:0] al_wdata, al_load, load_val;
  logic [3:0]  al_be;
  logic [1:0]  fault_pre;
  logic        access, timeout, complete;
  logic        cap_vld;
  logic [31:0] cap_load;
  logic [1:0]  cap_fault;

  mem_lane_align u_align (
    .addr_lo_i (ALU_co_pype[1:0]),
    .dsize_i   (dsize_pype2),
    .funct3_i  (funct3_pype2),
    .sdata_i   (read_data2_pype2),
    .rdata_i   (dmem_rdata),
    .wdata_o   (al_wdata),
    .be_o      (al_be),
    .load_o    (al_load)
  );

  assign fault_pre = pre_fault(MemRW_pype2, dsize_pype2, ALU_co_pype[1:0]);
  assign access    = (|MemRW_pype2) && (fault_pre == MEM_FAULT_OK);
  // The TIMEOUT_CYCLES-th BUSY cycle without ack completes the access as a fault.
  assign timeout   = (state_q == MEM_BUSY) && !dmem_ack && (cnt_q == TO_LAST);
  assign complete  = (state_q == MEM_BUSY) && (dmem_ack || timeout);
  assign load_val  = MemRW_pype2[MEMRW_LOAD] ? al_load : 32'd0;

  // Stall is forced low under reset so every output reads 0 then.
  assign mem_stall = rst && (((state_q == MEM_IDLE) && access) ||
                             ((state_q == MEM_BUSY) && !complete));

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  // What MEM/WB would take this cycle; cap_vld=0 means the stage is stalled (bubble).
  always_comb begin
    cap_vld   = 1'b0;
    cap_load  = 32'd0;
    cap_fault = MEM_FAULT_OK;
    case (state_q)
      MEM_IDLE: if (!access) begin
        cap_vld   = 1'b1;
        cap_fault = fault_pre;
      end
      MEM_BUSY: if (complete) begin
        cap_vld   = 1'b1;
        cap_load  = timeout ? 32'd0 : load_val;
        cap_fault = timeout ? MEM_FAULT_TIMEOUT : MEM_FAULT_OK;
      end
      MEM_DONE: begin
        cap_vld   = 1'b1;
        cap_load  = done_load_q;
        cap_fault = done_fault_q;
      end
      default: ;
    endcase
  end

  // Bus FSM: issue, hold until ack/timeout, park the result in DONE while keep is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= MEM_IDLE;
      cnt_q        <= 8'd0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      done_load_q  <= 32'd0;
      done_fault_q <= MEM_FAULT_OK;
    end else begin
      case (state_q)
        MEM_IDLE: if (access && !keep) begin
          state_q <= MEM_BUSY;
          req_q   <= 1'b1;
          we_q    <= MemRW_pype2[MEMRW_STORE];
          addr_q  <= {ALU_co_pype[31:2], 2'b00};
          wdata_q <= al_wdata;
          be_q    <= al_be;
          cnt_q   <= 8'd0;
        end
        MEM_BUSY: if (complete) begin
          req_q <= 1'b0;
          if (keep) begin
            state_q      <= MEM_DONE;
            done_load_q  <= cap_load;
            done_fault_q <= cap_fault;
          end else begin
            state_q <= MEM_IDLE;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        MEM_DONE: if (!keep) state_q <= MEM_IDLE;
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  // MEM/WB: keep holds, nop or a stall inserts a bubble, otherwise capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_data_pype3         <= 32'd0;
      ALU_co_pype3            <= 32'd0;
      PCp4_pype3              <= 32'd0;
      WReg_pype3              <= 5'd0;
      writeback_control_pype3 <= 3'd0;
      mem_fault_pype3         <= MEM_FAULT_OK;
    end else if (keep) begin
      // hold
    end else if (nop || !cap_vld) begin
      WReg_pype3              <= 5'd0;
      writeback_control_pype3 <= 3'd0;
      mem_fault_pype3         <= MEM_FAULT_OK;
    end else begin
      load_data_pype3         <= cap_load;
      ALU_co_pype3            <= ALU_co_pype;
      PCp4_pype3              <= PCp4_pype2;
      WReg_pype3              <= (cap_fault == MEM_FAULT_OK) ? WReg_pype2 : 5'd0;
      writeback_control_pype3 <= (cap_fault == MEM_FAULT_OK) ? writeback_control_pype2 : 3'd0;
      mem_fault_pype3         <= cap_fault;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus keep/timeout/reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst, keep, nop;
  logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2;
  logic [4:0]  WReg_pype2;
  logic [2:0]  writeback_control_pype2;
  logic [1:0]  MemRW_pype2, dsize_pype2;
  logic [2:0]  funct3_pype2;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] load_data_pype3, ALU_co_pype3, PCp4_pype3;
  logic [4:0]  WReg_pype3;
  logic [2:0]  writeback_control_pype3;
  logic [1:0]  mem_fault_pype3;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
    .PCp4_pype2(PCp4_pype2), .WReg_pype2(WReg_pype2),
    .writeback_control_pype2(writeback_control_pype2),
    .MemRW_pype2(MemRW_pype2), .dsize_pype2(dsize_pype2), .funct3_pype2(funct3_pype2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .load_data_pype3(load_data_pype3), .ALU_co_pype3(ALU_co_pype3),
    .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
    .writeback_control_pype3(writeback_control_pype3),
    .mem_fault_pype3(mem_fault_pype3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  rw;
    logic [1:0]  ds;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;     // BUSY cycles without ack before the ack cycle
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
    logic [1:0]  fault;
    int          stalls;
  } vec_t;

  vec_t vt[12];

  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we;

  task automatic idle_inputs();
    MemRW_pype2 = 2'b00; dsize_pype2 = 2'b00; funct3_pype2 = 3'b000;
    ALU_co_pype = 32'hA5A5_A5A5; read_data2_pype2 = 32'd0; PCp4_pype2 = 32'd0;
    WReg_pype2 = 5'd0; writeback_control_pype2 = 3'd0;
    keep = 1'b0; nop = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  // Present one instruction, answer the bus after v.dly BUSY cycles, return at posedge+1 after capture.
  task automatic run_txn(input vec_t v, input logic [4:0] wr, output int stalls, output int reqs);
    @(negedge clk);
    MemRW_pype2 = v.rw; dsize_pype2 = v.ds; funct3_pype2 = v.f3;
    ALU_co_pype = v.addr; read_data2_pype2 = v.sdata; PCp4_pype2 = v.addr + 32'd4;
    WReg_pype2 = wr; writeback_control_pype2 = 3'b101;
    stalls = 0; reqs = 0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req) begin
        reqs++;
        bus_addr = dmem_addr; bus_we = dmem_we; bus_be = dmem_be; bus_wdata = dmem_wdata;
        dmem_ack = (reqs > v.dly); dmem_rdata = v.rdata;
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      if (!mem_stall) break;
      stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int st, rq;
    vec_t v;
    logic [4:0] wr;

    //      rw     ds     f3      addr          sdata         rdata         dly be      wdata         load          fault  stalls
    vt[0]  = '{2'b01, 2'b10, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        3, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2'b00, 4};
    vt[1]  = '{2'b10, 2'b00, 3'b000, 32'h0000_0203, 32'h0,        32'h8012_3456, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 2'b00, 1};
    vt[2]  = '{2'b10, 2'b00, 3'b100, 32'h0000_0203, 32'h0,        32'h8012_3456, 0, 4'b0000, 32'h0,        32'h0000_0080, 2'b00, 1};
    vt[3]  = '{2'b01, 2'b00, 3'b000, 32'h0000_0203, 32'h0000_005A, 32'h0,        1, 4'b1000, 32'h5A00_0000, 32'h0,        2'b00, 2};
    vt[4]  = '{2'b10, 2'b01, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01, 0};
    vt[5]  = '{2'b10, 2'b01, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7777, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 2'b00, 1};
    vt[6]  = '{2'b10, 2'b01, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7777, 2, 4'b0000, 32'h0,        32'h0000_8001, 2'b00, 3};
    vt[7]  = '{2'b01, 2'b01, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,        0, 4'b1100, 32'hBEEF_0000, 32'h0,        2'b00, 1};
    vt[8]  = '{2'b10, 2'b10, 3'b010, 32'h0000_0206, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01, 0};
    vt[9]  = '{2'b11, 2'b10, 3'b010, 32'h0000_0300, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b11, 0};
    vt[10] = '{2'b00, 2'b00, 3'b000, 32'h0001_2345, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b00, 0};
    vt[11] = '{2'b10, 2'b10, 3'b011, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 2, 4'b0000, 32'h0,        32'hCAFE_F00D, 2'b00, 3};

    // Reset state, with a valid load presented so stall gating is exercised.
    idle_inputs();
    rst = 1'b0;
    MemRW_pype2 = 2'b10; ALU_co_pype = 32'h0000_0100; dsize_pype2 = 2'b10;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wreg", {27'd0, WReg_pype3}, 32'd0);
    chk("rst_load", load_data_pype3, 32'd0);
    chk("rst_fault", {30'd0, mem_fault_pype3}, 32'd0);
    idle_inputs();
    @(negedge clk) rst = 1'b1;

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      wr = 5'(i + 1);
      run_txn(vt[i], wr, st, rq);
      chk($sformatf("v%0d_stalls", i), st, vt[i].stalls);
      chk($sformatf("v%0d_fault", i), {30'd0, mem_fault_pype3}, {30'd0, vt[i].fault});
      chk($sformatf("v%0d_wreg", i), {27'd0, WReg_pype3}, (vt[i].fault != 2'b00) ? 32'd0 : {27'd0, wr});
      chk($sformatf("v%0d_wbc", i), {29'd0, writeback_control_pype3}, (vt[i].fault != 2'b00) ? 32'd0 : 32'd5);
      chk($sformatf("v%0d_load", i), load_data_pype3, vt[i].load);
      chk($sformatf("v%0d_alu", i), ALU_co_pype3, vt[i].addr);
      chk($sformatf("v%0d_pc4", i), PCp4_pype3, vt[i].addr + 32'd4);
      chk($sformatf("v%0d_req_after", i), {31'd0, dmem_req}, 32'd0);
      if (vt[i].stalls == 0) begin
        chk($sformatf("v%0d_noreq", i), rq, 0);
      end else begin
        chk($sformatf("v%0d_reqcyc", i), rq, vt[i].dly + 1);
        chk($sformatf("v%0d_addr", i), bus_addr, {vt[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_we", i), {31'd0, bus_we}, {31'd0, vt[i].rw[0]});
        if (vt[i].rw[0]) begin
          chk($sformatf("v%0d_be", i), {28'd0, bus_be}, {28'd0, vt[i].be});
          chk($sformatf("v%0d_wdata", i), bus_wdata, vt[i].wdata);
        end
      end
      idle_inputs();
    end

    // Timeout: lw never acked, TIMEOUT_CYCLES=4.
    v = '{2'b10, 2'b10, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 1000, 4'b0, 32'h0, 32'h0, 2'b10, 4};
    run_txn(v, 5'd20, st, rq);
    chk("to_reqcyc", rq, 4);
    chk("to_stalls", st, 4);
    chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to_fault", {30'd0, mem_fault_pype3}, 32'd2);
    chk("to_wreg", {27'd0, WReg_pype3}, 32'd0);
    chk("to_wbc", {29'd0, writeback_control_pype3}, 32'd0);
    idle_inputs();

    // Ack while keep=1: park in DONE for two cycles, then release.
    @(negedge clk);
    MemRW_pype2 = 2'b10; dsize_pype2 = 2'b10; funct3_pype2 = 3'b010;
    ALU_co_pype = 32'h0000_0500; PCp4_pype2 = 32'h0000_0504;
    WReg_pype2 = 5'd9; writeback_control_pype2 = 3'b011;
    #1 chk("dn_issue_stall", {31'd0, mem_stall}, 32'd1);
    @(negedge clk);
    chk("dn_req", {31'd0, dmem_req}, 32'd1);
    keep = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1 chk("dn_ack_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    chk("dn_noreq1", {31'd0, dmem_req}, 32'd0);
    #1 chk("dn_stall", {31'd0, mem_stall}, 32'd0);
    chk("dn_hold_load", load_data_pype3, 32'd0);
    chk("dn_hold_wreg", {27'd0, WReg_pype3}, 32'd0);
    @(negedge clk);
    chk("dn_noreq2", {31'd0, dmem_req}, 32'd0);
    keep = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    @(posedge clk); #1;
    chk("dn_load", load_data_pype3, 32'h1234_5678);
    chk("dn_wreg", {27'd0, WReg_pype3}, 32'd9);
    chk("dn_fault", {30'd0, mem_fault_pype3}, 32'd0);
    idle_inputs();
    @(negedge clk);
    chk("dn_noreissue", {31'd0, dmem_req}, 32'd0);

    // Reset while BUSY.
    MemRW_pype2 = 2'b10; dsize_pype2 = 2'b10; funct3_pype2 = 3'b010;
    ALU_co_pype = 32'h0000_0600; WReg_pype2 = 5'd11;
    @(negedge clk);
    chk("rb_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rb_stall", {31'd0, mem_stall}, 32'd0);
    chk("rb_alu", ALU_co_pype3, 32'd0);
    chk("rb_load", load_data_pype3, 32'd0);
    chk("rb_pc4", PCp4_pype3, 32'd0);
    idle_inputs();
    @(negedge clk) rst = 1'b1;
    v = '{2'b10, 2'b10, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 0, 4'b0, 32'h0, 32'h0BAD_F00D, 2'b00, 1};
    run_txn(v, 5'd12, st, rq);
    chk("rb_after_stalls", st, 1);
    chk("rb_after_reqcyc", rq, 1);
    chk("rb_after_load", load_data_pype3, 32'h0BAD_F00D);
    chk("rb_after_wreg", {27'd0, WReg_pype3}, 32'd12);
    idle_inputs();

    // keep / nop priority on a non-memory instruction.
    @(negedge clk);
    ALU_co_pype = 32'h0000_0011; WReg_pype2 = 5'd7; writeback_control_pype2 = 3'b011;
    @(posedge clk); #1 chk("kn_cap", {27'd0, WReg_pype3}, 32'd7);
    @(negedge clk); WReg_pype2 = 5'd9; keep = 1'b1;
    @(posedge clk); #1 chk("kn_keep", {27'd0, WReg_pype3}, 32'd7);
    @(negedge clk); nop = 1'b1;
    @(posedge clk); #1 chk("kn_keep_nop", {27'd0, WReg_pype3}, 32'd7);
    @(negedge clk); keep = 1'b0;
    @(posedge clk); #1;
    chk("kn_nop_wreg", {27'd0, WReg_pype3}, 32'd0);
    chk("kn_nop_wbc", {29'd0, writeback_control_pype3}, 32'd0);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
